// File: rtl/vie_axi_arbiter.sv
// ---------------------------------------------------------------------------
// vie_axi_arbiter
//
// Bridges the core's two sram-like ports onto a single AXI3 master. The
// instruction port is read-only. The data port issues reads and writes.
// There is one outstanding read and one outstanding write on the bus. The
// data port never has more than one outstanding transaction, so read-after-
// write ordering is kept without help from the interconnect.
//
// Ports:
//   clock, resetn              clock, asynchronous active-low reset
//   inst_*                     fetch port (req/addr in, addr_ok/data_ok/rdata out)
//   data_*                     load/store port (req/wr/size/addr/wdata in,
//                              addr_ok/data_ok/rdata out)
//   ar*, r*                    AXI read address / read data channels
//   aw*, w*, b*                AXI write address / write data / response channels
// ---------------------------------------------------------------------------
module vie_axi_arbiter (
  input  logic        clock,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

  rd_state_t   r_state_q, r_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_size_q, ar_size_d;
  logic [3:0]  ar_id_q, ar_id_d;

  wr_state_t   w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [1:0]  w_size_q, w_size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic rd_data_grant, rd_inst_grant, wr_grant, read_holds_data, r_beat;

  // Response/ID fields that this single-beat, error-ignoring bridge never needs.
  logic unused_bits;
  assign unused_bits = ^{rresp, rlast, bid, bresp};

  // Grants are gated with resetn so no addr_ok can escape while reset is held.
  assign read_holds_data = (r_state_q != R_IDLE) && (ar_id_q == 4'd1);
  assign rd_data_grant   = resetn && (r_state_q == R_IDLE) && data_req && !data_wr
                           && (w_state_q == W_IDLE);
  assign rd_inst_grant   = resetn && (r_state_q == R_IDLE) && inst_req && !rd_data_grant;
  assign wr_grant        = resetn && (w_state_q == W_IDLE) && data_req && data_wr
                           && !read_holds_data;
  assign r_beat          = (r_state_q == R_R) && rvalid;

  assign inst_addr_ok = rd_inst_grant;
  assign data_addr_ok = rd_data_grant || wr_grant;
  assign inst_data_ok = r_beat && (rid == 4'd0);
  assign data_data_ok = (r_beat && (rid == 4'd1)) || ((w_state_q == W_RESP) && bvalid);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // Read channel outputs
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);

  // Write channel outputs
  assign awid    = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, w_size_q};
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (w_state_q == W_REQ) && !aw_done_q;
  assign wid     = 4'd1;
  assign wdata   = w_data_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state_q == W_REQ) && !w_done_q;
  assign bready  = (w_state_q == W_RESP);

  // Store data arrives already lane-aligned; only the strobe needs deriving.
  always_comb begin
    case (w_size_q)
      2'd0:    wstrb = 4'b0001 << aw_addr_q[1:0];
      2'd1:    wstrb = aw_addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_size_d = ar_size_q;
    ar_id_d   = ar_id_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_data_grant) begin
          ar_addr_d = data_addr;
          ar_size_d = data_size;
          ar_id_d   = 4'd1;
          r_state_d = R_AR;
        end else if (rd_inst_grant) begin
          ar_addr_d = inst_addr;
          ar_size_d = 2'd2;
          ar_id_d   = 4'd0;
          r_state_d = R_AR;
        end
      end
      R_AR:    if (arready) r_state_d = R_R;
      R_R:     if (rvalid)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state. AW and W complete independently; the *_done flags
  // remember which handshake has already happened.
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_size_d  = w_size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_grant) begin
          aw_addr_d = data_addr;
          w_data_d  = data_wdata;
          w_size_d  = data_size;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if ((aw_done_q || awready) && (w_done_q || wready)) w_state_d = W_RESP;
      end
      W_RESP:  if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= 32'd0;
      ar_size_q <= 2'd0;
      ar_id_q   <= 4'd0;
      w_state_q <= W_IDLE;
      aw_addr_q <= 32'd0;
      w_data_q  <= 32'd0;
      w_size_q  <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      ar_size_q <= ar_size_d;
      ar_id_q   <= ar_id_d;
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_size_q  <= w_size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_vie_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vie_axi_arbiter
//
// Directed bench. Inputs change 1 ns after the rising edge. Outputs are
// checked 1 ns later, well away from the next edge. The AXI slave side is
// driven by hand with the response timing each scenario needs.
// ---------------------------------------------------------------------------
module tb_vie_axi_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  vie_axi_arbiter dut (
    .clock(clock), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;

    // ---------------- reset state
    repeat (3) cyc();
    #1;
    check("rst_arvalid", {31'd0, arvalid}, 0);
    check("rst_awvalid", {31'd0, awvalid}, 0);
    check("rst_wvalid",  {31'd0, wvalid}, 0);
    check("rst_rready",  {31'd0, rready}, 0);
    check("rst_bready",  {31'd0, bready}, 0);
    check("rst_araddr",  araddr, 0);
    check("rst_awaddr",  awaddr, 0);
    check("rst_ok", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    cyc();
    resetn = 1'b1;

    // ---------------- instruction fetch
    cyc();
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    check("if_addr_ok", {31'd0, inst_addr_ok}, 1);
    check("if_daddr_ok", {31'd0, data_addr_ok}, 0);
    cyc();
    inst_req = 0; arready = 1;
    #1;
    check("if_arvalid", {31'd0, arvalid}, 1);
    check("if_araddr", araddr, 32'hBFC0_0000);
    check("if_arid", {28'd0, arid}, 0);
    check("if_arsize", {29'd0, arsize}, 2);
    check("if_arlen", {24'd0, arlen}, 0);
    check("if_arburst", {30'd0, arburst}, 1);
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h3C1D_8000;
    #1;
    check("if_rready", {31'd0, rready}, 1);
    check("if_data_ok", {31'd0, inst_data_ok}, 1);
    check("if_rdata", inst_rdata, 32'h3C1D_8000);
    check("if_ddata_ok", {31'd0, data_data_ok}, 0);
    cyc();
    rvalid = 0;
    #1;
    check("if_idle_arvalid", {31'd0, arvalid}, 0);
    check("if_idle_rready", {31'd0, rready}, 0);
    $display("TXN inst fetch addr=0xbfc00000 data=0x%08h", inst_rdata);

    // ---------------- contention: data read beats inst
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_1000;
    #1;
    check("ct_daddr_ok", {31'd0, data_addr_ok}, 1);
    check("ct_iaddr_ok", {31'd0, inst_addr_ok}, 0);
    cyc();
    data_req = 0; arready = 1;
    #1;
    check("ct_arid", {28'd0, arid}, 1);
    check("ct_araddr", araddr, 32'h8000_1000);
    check("ct_iaddr_ok_busy", {31'd0, inst_addr_ok}, 0);
    cyc();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h1234_5678;
    #1;
    check("ct_ddata_ok", {31'd0, data_data_ok}, 1);
    check("ct_drdata", data_rdata, 32'h1234_5678);
    check("ct_idata_ok", {31'd0, inst_data_ok}, 0);
    cyc();
    rvalid = 0;
    #1;
    check("ct_inst_after", {31'd0, inst_addr_ok}, 1);
    cyc();
    inst_req = 0; arready = 1;
    #1;
    check("ct_inst_arid", {28'd0, arid}, 0);
    check("ct_inst_araddr", araddr, 32'hBFC0_0004);
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'hCAFE_0001;
    #1;
    check("ct_inst_data_ok", {31'd0, inst_data_ok}, 1);
    cyc();
    rvalid = 0;
    $display("TXN contention: data read 0x80001000 then inst 0xbfc00004");

    // ---------------- byte store
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    #1;
    check("bs_addr_ok", {31'd0, data_addr_ok}, 1);
    cyc();
    data_req = 0; awready = 1; wready = 1;
    #1;
    check("bs_awvalid", {31'd0, awvalid}, 1);
    check("bs_wvalid", {31'd0, wvalid}, 1);
    check("bs_awsize", {29'd0, awsize}, 0);
    check("bs_wstrb", {28'd0, wstrb}, 4'b1000);
    check("bs_awaddr", awaddr, 32'h8000_0003);
    check("bs_wdata", wdata, 32'hAB00_0000);
    check("bs_ids_last", {23'd0, awid, wid, wlast}, {23'd0, 4'd1, 4'd1, 1'b1});
    cyc();
    awready = 0; wready = 0; bvalid = 1;
    #1;
    check("bs_bready", {31'd0, bready}, 1);
    check("bs_data_ok", {31'd0, data_data_ok}, 1);
    check("bs_awvalid_off", {31'd0, awvalid}, 0);
    cyc();
    bvalid = 0;
    #1;
    check("bs_done", {30'd0, data_data_ok, bready}, 0);
    $display("TXN byte store addr=0x80000003 strb=1000");

    // ---------------- halfword store with W lagging AW by 3 cycles
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h8000_0002; data_wdata = 32'h5566_0000;
    #1;
    check("hs_addr_ok", {31'd0, data_addr_ok}, 1);
    cyc();
    data_req = 0; awready = 1;
    #1;
    check("hs_wstrb", {28'd0, wstrb}, 4'b1100);
    check("hs_awsize", {29'd0, awsize}, 1);
    check("hs_valids", {30'd0, awvalid, wvalid}, 2'b11);
    cyc();
    awready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hs_aw_dropped", {30'd0, awvalid, wvalid}, 2'b01);
      cyc();
    end
    wready = 1;
    #1;
    check("hs_w_hs", {30'd0, awvalid, wvalid}, 2'b01);
    cyc();
    wready = 0;
    #1;
    check("hs_resp", {29'd0, awvalid, wvalid, bready}, 3'b001);
    cyc();
    bvalid = 1;
    #1;
    check("hs_data_ok", {31'd0, data_data_ok}, 1);
    cyc();
    bvalid = 0;
    $display("TXN half store addr=0x80000002 strb=1100 (wready +3)");

    // ---------------- arready held off for 5 cycles
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    #1;
    check("ar_wait_accept", {31'd0, inst_addr_ok}, 1);
    cyc();
    inst_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("ar_wait_valid", {31'd0, arvalid}, 1);
      check("ar_wait_addr", araddr, 32'hBFC0_0010);
      check("ar_wait_id", {28'd0, arid}, 0);
      cyc();
    end
    arready = 1;
    #1;
    check("ar_wait_hs", {31'd0, arvalid}, 1);
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_0BAD;
    #1;
    check("ar_wait_data", inst_rdata, 32'h0000_0BAD);
    cyc();
    rvalid = 0;
    $display("TXN inst fetch 0xbfc00010 with arready delayed 5 cycles");

    // ---------------- ordering: read waits for outstanding write
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    #1;
    check("or_wr_accept", {31'd0, data_addr_ok}, 1);
    cyc();
    data_req = 0; awready = 1; wready = 1;
    #1;
    check("or_wstrb", {28'd0, wstrb}, 4'b1111);
    cyc();
    awready = 0; wready = 0;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0020;
    inst_req = 1; inst_addr = 32'hBFC0_0020;
    #1;
    check("or_rd_blocked", {31'd0, data_addr_ok}, 0);
    check("or_inst_go", {31'd0, inst_addr_ok}, 1);
    cyc();
    inst_req = 0; arready = 1;
    #1;
    check("or_inst_arid", {28'd0, arid}, 0);
    check("or_rd_blocked2", {31'd0, data_addr_ok}, 0);
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h1111_2222;
    #1;
    check("or_inst_data_ok", {31'd0, inst_data_ok}, 1);
    check("or_rd_blocked3", {31'd0, data_addr_ok}, 0);
    cyc();
    rvalid = 0; bvalid = 1;
    #1;
    check("or_wr_done", {31'd0, data_data_ok}, 1);
    check("or_rd_blocked4", {31'd0, data_addr_ok}, 0);
    cyc();
    bvalid = 0;
    #1;
    check("or_rd_accept", {31'd0, data_addr_ok}, 1);
    cyc();
    data_req = 0; arready = 1;
    #1;
    check("or_rd_arid", {28'd0, arid}, 1);
    check("or_rd_araddr", araddr, 32'h8000_0020);
    cyc();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'hDEAD_BEEF;
    #1;
    check("or_rd_data", data_rdata, 32'hDEAD_BEEF);
    check("or_rd_data_ok", {31'd0, data_data_ok}, 1);
    cyc();
    rvalid = 0;
    $display("TXN ordering: store 0x80000010 then load 0x80000020");

    // ---------------- asynchronous reset in the middle of R_AR
    inst_req = 1; inst_addr = 32'hBFC0_0040;
    cyc();
    inst_req = 0;
    #1;
    check("mr_arvalid_pre", {31'd0, arvalid}, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mr_arvalid", {31'd0, arvalid}, 0);
    check("mr_araddr", araddr, 0);
    check("mr_ok", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    cyc();
    resetn = 1'b1;
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    check("mr_first_accept", {31'd0, inst_addr_ok}, 1);
    cyc();
    inst_req = 0;
    #1;
    check("mr_araddr_after", araddr, 32'hBFC0_0000);
    $display("TXN reset mid-AR, refetch 0xbfc00000 accepted");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
